// File: rtl/ex_mem_pkg.sv
// Shared types and helpers for the EX/MEM pipeline stage: control bundle,
// occupancy encoding and payload width arithmetic.
package ex_mem_pkg;

    localparam int CTRL_W = 6;

    typedef struct packed {
        logic [1:0] reg_write;
        logic [1:0] mem_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    // Encoding doubles as the number of valid entries held.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_SKID  = 2'd2
    } occ_t;

    localparam int SHADOW_W = 3;

    function automatic int payload_w(input int data_w, input int reg_aw);
        return (4 * data_w) + reg_aw + CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_stage_buf_skid2.sv
// Generic two-entry skid buffer (main + skid register) with registered
// in_ready, a flush that empties it, and zeroing of the low GATE_W bits
// whenever the buffer becomes empty.
module stage_skid2
    import ex_mem_pkg::*;
#(
    parameter int W      = 8,
    parameter int GATE_W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   held_cnt
);

    localparam logic [W-1:0] KEEP_MASK = {{(W - GATE_W){1'b1}}, {GATE_W{1'b0}}};

    occ_t           occ_d, occ_q;
    logic [W-1:0]   main_d, main_q;
    logic [W-1:0]   main_n_s;
    logic [W-1:0]   skid_d, skid_q;
    logic           in_ready_d, in_ready_q;
    logic           accept_s;
    logic           deliver_s;

    // Next occupancy and data movement; flush wins over accept and deliver.
    always_comb begin
        accept_s  = in_valid & in_ready_q & ~flush;
        deliver_s = (occ_q != OCC_EMPTY) & out_ready;
        occ_d     = occ_q;
        main_n_s  = main_q;
        skid_d    = skid_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        main_n_s = in_data;
                        occ_d    = OCC_ONE;
                    end else begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && deliver_s) begin
                        main_n_s = in_data;
                    end else if (accept_s) begin
                        skid_d = in_data;
                        occ_d  = OCC_SKID;
                    end else if (deliver_s) begin
                        occ_d = OCC_EMPTY;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
                OCC_SKID: begin
                    if (deliver_s) begin
                        main_n_s = skid_q;
                        occ_d    = OCC_ONE;
                    end else begin
                        occ_d = OCC_SKID;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // Gated bits are cleared whenever nothing will be presented next edge.
    always_comb begin
        if (occ_d == OCC_EMPTY) begin
            main_d = main_n_s & KEEP_MASK;
        end else begin
            main_d = main_n_s;
        end
        in_ready_d = (occ_d != OCC_SKID);
    end

    // Buffer state registers, updated on the falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= OCC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign held_cnt  = occ_q;

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline stage: handshake over a two-entry skid buffer, plus a
// post-flush shadow that discards wrong-path input and a squash counter.
module ex_mem_stage_buf
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int SHADOW = 1,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_btarget,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [DATA_W-1:0] in_r0,
    input  logic [REG_AW-1:0] in_wb_addr,
    input  logic [1:0]        in_reg_write,
    input  logic [1:0]        in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              in_branch,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_btarget,
    output logic [DATA_W-1:0] out_sdata,
    output logic [DATA_W-1:0] out_r0,
    output logic [REG_AW-1:0] out_wb_addr,
    output logic [1:0]        out_reg_write,
    output logic [1:0]        out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_branch,
    output logic [STAT_W-1:0] squash_cnt
);

    localparam int                  PW            = payload_w(DATA_W, REG_AW);
    localparam logic [SHADOW_W-1:0] SHADOW_RELOAD = SHADOW_W'(SHADOW);

    ctrl_t               in_ctrl_s;
    ctrl_t               out_ctrl_s;
    logic [PW-1:0]       in_pl_s;
    logic [PW-1:0]       out_pl_s;
    logic                shadow_busy_s;
    logic                skid_in_valid_s;
    logic                drop_in_s;
    logic [1:0]          held_cnt_s;
    logic [1:0]          squash_add_s;
    logic [STAT_W+1:0]   squash_sum_s;
    logic [SHADOW_W-1:0] shadow_d, shadow_q;
    logic [STAT_W-1:0]   squash_d, squash_q;

    // Control bits sit in the low end so the buffer can gate them.
    always_comb begin
        in_ctrl_s.reg_write  = in_reg_write;
        in_ctrl_s.mem_write  = in_mem_write;
        in_ctrl_s.mem_to_reg = in_mem_to_reg;
        in_ctrl_s.branch     = in_branch;
        in_pl_s = {in_alu, in_btarget, in_sdata, in_r0, in_wb_addr, in_ctrl_s};
    end

    assign {out_alu, out_btarget, out_sdata, out_r0, out_wb_addr, out_ctrl_s} = out_pl_s;
    assign out_reg_write  = out_ctrl_s.reg_write;
    assign out_mem_write  = out_ctrl_s.mem_write;
    assign out_mem_to_reg = out_ctrl_s.mem_to_reg;
    assign out_branch     = out_ctrl_s.branch;

    assign shadow_busy_s   = (shadow_q != {SHADOW_W{1'b0}});
    assign skid_in_valid_s = in_valid & ~shadow_busy_s;

    stage_skid2 #(
        .W      (PW),
        .GATE_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (skid_in_valid_s),
        .in_ready  (in_ready),
        .in_data   (in_pl_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl_s),
        .held_cnt  (held_cnt_s)
    );

    // Shadow reloads on every flush and otherwise counts down to zero.
    always_comb begin
        if (flush) begin
            shadow_d = SHADOW_RELOAD;
        end else if (shadow_busy_s) begin
            shadow_d = shadow_q - {{(SHADOW_W-1){1'b0}}, 1'b1};
        end else begin
            shadow_d = {SHADOW_W{1'b0}};
        end
    end

    // Squashed entries this edge: held entries at flush plus a dropped input.
    always_comb begin
        drop_in_s = in_valid & (flush | shadow_busy_s);
        if (flush) begin
            squash_add_s = held_cnt_s + {1'b0, drop_in_s};
        end else begin
            squash_add_s = {1'b0, drop_in_s};
        end
        squash_sum_s = (STAT_W+2)'(squash_q) + (STAT_W+2)'(squash_add_s);
        if (squash_sum_s[STAT_W+1:STAT_W] != 2'b00) begin
            squash_d = {STAT_W{1'b1}};
        end else begin
            squash_d = squash_sum_s[STAT_W-1:0];
        end
    end

    // Shadow and squash counter registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= {SHADOW_W{1'b0}};
            squash_q <= {STAT_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            squash_q <= squash_d;
        end
    end

    assign squash_cnt = squash_q;

endmodule
